// File: rtl/fetch_unit.sv
// Instruction-fetch stage: latches the PC on request, performs a handshaked
// read from instruction memory, holds the fetched word in the instruction
// register and derives the jump-target candidates from it.
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INSN_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetchEn,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pcCur,
    input  logic              memReady,
    input  logic [INSN_W-1:0] memData,
    output logic              memRead,
    output logic [ADDR_W-1:0] memAddr,
    output logic              busy,
    output logic              fetchDone,
    output logic              irValid,
    output logic [INSN_W-1:0] irOut,
    output logic [ADDR_W-1:0] pcOfIr,
    output logic              alignErr,
    output logic [ADDR_W-1:0] immPlusPC,
    output logic [ADDR_W-1:0] immAddr,
    output logic [ADDR_W-1:0] jcmpImm,
    output logic [ADDR_W-1:0] jcmpImmLS
);

    // IDLE: no request outstanding. WAIT: read issued, data wanted.
    // DRAIN: read issued but flushed; the memory must still complete the
    // handshake before a new request may be issued, so its data is dropped.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetchState_t;

    fetchState_t       state;
    fetchState_t       stateNext;

    logic              memReadNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic              busyNext;
    logic              fetchDoneNext;
    logic              irValidNext;
    logic [INSN_W-1:0] irOutNext;
    logic [ADDR_W-1:0] pcOfIrNext;
    logic              alignErrNext;

    // Two's-complement sign extension of the 12-bit jump immediate.
    function automatic logic signed [ADDR_W-1:0] sext12(input logic [11:0] v);
        sext12 = {{(ADDR_W-12){v[11]}}, v};
    endfunction

    // Two's-complement sign extension of the 4-bit compare-and-jump offset.
    function automatic logic signed [ADDR_W-1:0] sext4(input logic [3:0] v);
        sext4 = {{(ADDR_W-4){v[3]}}, v};
    endfunction

    // State and all registered outputs; reset abandons any outstanding read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            memRead   <= 1'b0;
            memAddr   <= '0;
            busy      <= 1'b0;
            fetchDone <= 1'b0;
            irValid   <= 1'b0;
            irOut     <= '0;
            pcOfIr    <= '0;
            alignErr  <= 1'b0;
        end else begin
            state     <= stateNext;
            memRead   <= memReadNext;
            memAddr   <= memAddrNext;
            busy      <= busyNext;
            fetchDone <= fetchDoneNext;
            irValid   <= irValidNext;
            irOut     <= irOutNext;
            pcOfIr    <= pcOfIrNext;
            alignErr  <= alignErrNext;
        end
    end

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        stateNext     = state;
        memReadNext   = memRead;
        memAddrNext   = memAddr;
        busyNext      = busy;
        fetchDoneNext = 1'b0;
        irValidNext   = irValid;
        irOutNext     = irOut;
        pcOfIrNext    = pcOfIr;
        alignErrNext  = alignErr;

        case (state)
            IDLE: begin
                if (flush) begin
                    // flush outranks a simultaneous request; the IR contents
                    // are kept, only their validity is withdrawn
                    irValidNext = 1'b0;
                end else if (fetchEn) begin
                    if (pcCur[0]) begin
                        alignErrNext = 1'b1;
                    end else begin
                        memAddrNext = pcCur;
                        memReadNext = 1'b1;
                        busyNext    = 1'b1;
                        irValidNext = 1'b0;
                        stateNext   = WAIT;
                    end
                end
            end

            WAIT: begin
                if (memReady) begin
                    memReadNext = 1'b0;
                    busyNext    = 1'b0;
                    stateNext   = IDLE;
                    if (!flush) begin
                        irOutNext     = memData;
                        pcOfIrNext    = memAddr;
                        irValidNext   = 1'b1;
                        fetchDoneNext = 1'b1;
                    end
                end else if (flush) begin
                    stateNext = DRAIN;
                end
            end

            DRAIN: begin
                if (memReady) begin
                    memReadNext = 1'b0;
                    busyNext    = 1'b0;
                    stateNext   = IDLE;
                end
            end

            default: begin
                stateNext   = IDLE;
                memReadNext = 1'b0;
                busyNext    = 1'b0;
            end
        endcase
    end

    // Jump-target candidates; all sums wrap modulo 2^ADDR_W.
    logic signed [ADDR_W-1:0] immOff;
    logic signed [ADDR_W-1:0] cmpOff;

    assign immOff    = sext12(irOut[11:0]);
    assign cmpOff    = sext4(irOut[3:0]);

    assign immPlusPC = pcOfIr + $unsigned(immOff <<< 1);
    assign immAddr   = {pcOfIr[ADDR_W-1:13], irOut[11:0], 1'b0};
    assign jcmpImm   = pcOfIr + $unsigned(cmpOff);
    assign jcmpImmLS = pcOfIr + $unsigned(cmpOff <<< 1);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected IR loads.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetchEn = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] pcCur = '0;
    logic        memReady = 1'b0;
    logic [15:0] memData = '0;
    logic        memRead;
    logic [15:0] memAddr;
    logic        busy;
    logic        fetchDone;
    logic        irValid;
    logic [15:0] irOut;
    logic [15:0] pcOfIr;
    logic        alignErr;
    logic [15:0] immPlusPC;
    logic [15:0] immAddr;
    logic [15:0] jcmpImm;
    logic [15:0] jcmpImmLS;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    logic [31:0] sb[$];

    fetch_unit #(.ADDR_W(16), .INSN_W(16)) dut (
        .clock(clock), .reset(reset), .fetchEn(fetchEn), .flush(flush),
        .pcCur(pcCur), .memReady(memReady), .memData(memData),
        .memRead(memRead), .memAddr(memAddr), .busy(busy),
        .fetchDone(fetchDone), .irValid(irValid), .irOut(irOut),
        .pcOfIr(pcOfIr), .alignErr(alignErr), .immPlusPC(immPlusPC),
        .immAddr(immAddr), .jcmpImm(jcmpImm), .jcmpImmLS(jcmpImmLS)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every IR load must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (fetchDone === 1'b1) begin
            doneCount++;
            if (sb.size() == 0) begin
                chk("unexpectedDone", 32'(fetchDone), 32'd0);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sbPcOfIr", 32'(pcOfIr), 32'(e[31:16]));
                chk("sbIrOut", 32'(irOut), 32'(e[15:0]));
            end
        end
    end

    // Complete fetch with 'lat' idle memory cycles before memReady.
    task automatic doFetch(input logic [15:0] addr, input logic [15:0] data, input int lat);
        sb.push_back({addr, data});
        pcCur = addr;
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        chk("reqRead", 32'(memRead), 32'd1);
        chk("reqAddr", 32'(memAddr), 32'(addr));
        chk("reqBusy", 32'(busy), 32'd1);
        chk("reqIrValid", 32'(irValid), 32'd0);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("holdRead", 32'(memRead), 32'd1);
            chk("holdAddr", 32'(memAddr), 32'(addr));
        end
        memReady = 1'b1;
        memData = data;
        tick();
        memReady = 1'b0;
        chk("doneHigh", 32'(fetchDone), 32'd1);
        chk("doneIrValid", 32'(irValid), 32'd1);
        chk("doneBusy", 32'(busy), 32'd0);
        chk("doneRead", 32'(memRead), 32'd0);
        tick();
        chk("doneOnePulse", 32'(fetchDone), 32'd0);
    endtask

    initial begin
        int doneBefore;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rstRead", 32'(memRead), 32'd0);
        chk("rstAddr", 32'(memAddr), 32'd0);
        chk("rstBusy", 32'(busy), 32'd0);
        chk("rstDone", 32'(fetchDone), 32'd0);
        chk("rstIrValid", 32'(irValid), 32'd0);
        chk("rstIrOut", 32'(irOut), 32'd0);
        chk("rstPcOfIr", 32'(pcOfIr), 32'd0);
        chk("rstAlign", 32'(alignErr), 32'd0);

        // Minimum-latency fetch
        doFetch(16'h0010, 16'hA123, 0);
        chk("t1IrOut", 32'(irOut), 32'h0000A123);
        chk("t1PcOfIr", 32'(pcOfIr), 32'h00000010);

        // Jump-target candidates
        doFetch(16'h0100, 16'h0FFE, 0);
        chk("immPlusPC_a", 32'(immPlusPC), 32'h000000FC);
        chk("immAddr_a", 32'(immAddr), 32'h00001FFC);
        chk("jcmpImm_a", 32'(jcmpImm), 32'h000000FE);
        chk("jcmpImmLS_a", 32'(jcmpImmLS), 32'h000000FC);
        doFetch(16'hFFF0, 16'h07FF, 1);
        chk("immPlusPC_b", 32'(immPlusPC), 32'h00000FEE);
        chk("immAddr_b", 32'(immAddr), 32'h0000EFFE);
        chk("jcmpImm_b", 32'(jcmpImm), 32'h0000FFEF);
        chk("jcmpImmLS_b", 32'(jcmpImmLS), 32'h0000FFEE);
        doFetch(16'hFFFE, 16'h0001, 0);
        chk("immPlusPC_c", 32'(immPlusPC), 32'h00000000);
        chk("immAddr_c", 32'(immAddr), 32'h0000E002);
        chk("jcmpImm_c", 32'(jcmpImm), 32'h0000FFFF);
        chk("jcmpImmLS_c", 32'(jcmpImmLS), 32'h00000000);

        // Slow memory with a second request while busy
        doneBefore = doneCount;
        sb.push_back({16'h0200, 16'h1234});
        pcCur = 16'h0200;
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                pcCur = 16'h0300;
                fetchEn = 1'b1;
            end else begin
                fetchEn = 1'b0;
            end
            tick();
            chk("slowRead", 32'(memRead), 32'd1);
            chk("slowAddr", 32'(memAddr), 32'h00000200);
        end
        fetchEn = 1'b0;
        memReady = 1'b1;
        memData = 16'h1234;
        tick();
        memReady = 1'b0;
        chk("slowPcOfIr", 32'(pcOfIr), 32'h00000200);
        tick();
        tick();
        chk("slowNoQueue", 32'(memRead), 32'd0);
        chk("slowOneDone", 32'(doneCount - doneBefore), 32'd1);

        // Flush while waiting: drain, no IR load
        doneBefore = doneCount;
        pcCur = 16'h0400;
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drainRead", 32'(memRead), 32'd1);
        chk("drainBusy", 32'(busy), 32'd1);
        tick();
        tick();
        chk("drainHold", 32'(memRead), 32'd1);
        memReady = 1'b1;
        memData = 16'hBEEF;
        tick();
        memReady = 1'b0;
        chk("drainReadLow", 32'(memRead), 32'd0);
        chk("drainBusyLow", 32'(busy), 32'd0);
        chk("drainIrValid", 32'(irValid), 32'd0);
        chk("drainIrOut", 32'(irOut), 32'h00001234);
        tick();
        chk("drainNoDone", 32'(doneCount - doneBefore), 32'd0);
        doFetch(16'h0500, 16'h5555, 1);

        // flush and fetchEn together in IDLE: no request, IR kept but invalid
        pcCur = 16'h0700;
        fetchEn = 1'b1;
        flush = 1'b1;
        tick();
        fetchEn = 1'b0;
        flush = 1'b0;
        chk("idleFlushRead", 32'(memRead), 32'd0);
        chk("idleFlushValid", 32'(irValid), 32'd0);
        chk("idleFlushIr", 32'(irOut), 32'h00005555);
        chk("idleFlushPc", 32'(pcOfIr), 32'h00000500);

        // flush and memReady in the same WAIT cycle: data dropped
        doneBefore = doneCount;
        pcCur = 16'h0800;
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        flush = 1'b1;
        memReady = 1'b1;
        memData = 16'hDEAD;
        tick();
        flush = 1'b0;
        memReady = 1'b0;
        chk("flushRdyRead", 32'(memRead), 32'd0);
        chk("flushRdyValid", 32'(irValid), 32'd0);
        chk("flushRdyIr", 32'(irOut), 32'h00005555);
        tick();
        chk("flushRdyNoDone", 32'(doneCount - doneBefore), 32'd0);

        // Misaligned request
        pcCur = 16'h0011;
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        chk("alignRead", 32'(memRead), 32'd0);
        chk("alignBusy", 32'(busy), 32'd0);
        chk("alignSet", 32'(alignErr), 32'd1);
        doFetch(16'h0020, 16'h4321, 0);
        chk("alignSticky", 32'(alignErr), 32'd1);

        // Reset during WAIT, late memReady ignored
        doneBefore = doneCount;
        pcCur = 16'h0600;
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstWaitRead", 32'(memRead), 32'd0);
        chk("rstWaitBusy", 32'(busy), 32'd0);
        chk("rstWaitValid", 32'(irValid), 32'd0);
        chk("rstWaitAlign", 32'(alignErr), 32'd0);
        memReady = 1'b1;
        memData = 16'h7777;
        tick();
        memReady = 1'b0;
        chk("lateRdyDone", 32'(fetchDone), 32'd0);
        chk("lateRdyIr", 32'(irOut), 32'd0);
        tick();
        chk("lateRdyNoDone", 32'(doneCount - doneBefore), 32'd0);
        chk("sbDrained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
